// File: rtl/ifft_sym_sched_if.sv
`default_nettype none
// ============================================================================
// ifft_sym_sched_if : Wishbone-style single-direction sample link
// Revision: 1.0
// ============================================================================
interface ifft_sym_sched_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [31:0] dat;

  modport master (output cyc, output stb, output we, output dat, input ack);
  modport slave  (input cyc, input stb, input we, input dat, output ack);
endinterface
`default_nettype wire

// File: rtl/ifft_sym_sched.sv
`default_nettype none
// ============================================================================
// ifft_sym_sched : frame sequencer from the symbol-mapper stream into an IFFT
//                  burst, forwarding NSYM x NFFT samples through one register
// Revision: 1.0
// ============================================================================
module ifft_sym_sched #(
  parameter int CFG_GAP = 2,
  parameter int NSYM_W  = 8
) (
  input  wire logic              CLK_I,
  input  wire logic              RST_I,
  input  wire logic              START_I,
  input  wire logic [1:0]        STD_I,
  input  wire logic [NSYM_W-1:0] NSYM_I,
  ifft_sym_sched_if.slave        up,
  ifft_sym_sched_if.master       dn,
  output logic [1:0]             STD_O,
  output logic                   BUSY_O,
  output logic                   DONE_O,
  output logic                   ERR_O
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CFG   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int                GAP_W    = (CFG_GAP > 1) ? $clog2(CFG_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(CFG_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [NSYM_W-1:0] NSYM_ONE = NSYM_W'(1);

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [10:0]       samp_q, samp_d;
  logic [10:0]       nfft_m1_q, nfft_m1_d;
  logic [NSYM_W-1:0] sym_q, sym_d;
  logic [NSYM_W-1:0] nsym_q, nsym_d;
  logic [1:0]        std_q, std_d;
  logic [31:0]       dat_q, dat_d;
  logic              stb_q, stb_d;
  logic              cyc_q, cyc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last_q, last_d;

  logic              acc;
  logic              cfg_ok;
  logic              frame_end;

  function automatic logic [10:0] nfft_m1(input logic [1:0] s);
    case (s)
      2'b00:   nfft_m1 = 11'd63;
      2'b01:   nfft_m1 = 11'd255;
      default: nfft_m1 = 11'd2047;
    endcase
  endfunction

  // The output register may take a new sample when empty or being drained this cycle.
  assign acc       = (state_q == S_RUN) & up.cyc & up.stb & up.we & (~stb_q | dn.ack) & ~last_q;
  assign cfg_ok    = (STD_I != 2'b11) && (NSYM_I != '0);
  assign frame_end = acc & (samp_q == nfft_m1_q) & (sym_q == nsym_q - NSYM_ONE);

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    samp_d    = samp_q;
    sym_d     = sym_q;
    nsym_d    = nsym_q;
    nfft_m1_d = nfft_m1_q;
    std_d     = std_q;
    dat_d     = dat_q;
    stb_d     = stb_q;
    cyc_d     = cyc_q;
    last_d    = last_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START_I) begin
          if (cfg_ok) begin
            std_d     = STD_I;
            nsym_d    = NSYM_I;
            nfft_m1_d = nfft_m1(STD_I);
            gap_d     = '0;
            state_d   = S_CFG;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CFG: begin
        cyc_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          cyc_d   = 1'b1;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      S_RUN: begin
        if (acc) begin
          dat_d = up.dat;
          stb_d = 1'b1;
          if (samp_q == nfft_m1_q) begin
            samp_d = '0;
            sym_d  = sym_q + NSYM_ONE;
          end else begin
            samp_d = samp_q + 11'd1;
          end
          if (frame_end) begin
            last_d  = 1'b1;
            state_d = S_DRAIN;
          end
        end else begin
          if (dn.ack) stb_d = 1'b0;
          if (!up.cyc) begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!stb_q || dn.ack) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          done_d  = last_q;
          samp_d  = '0;
          sym_d   = '0;
          gap_d   = '0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      samp_q    <= '0;
      sym_q     <= '0;
      nsym_q    <= '0;
      nfft_m1_q <= '0;
      std_q     <= '0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      samp_q    <= samp_d;
      sym_q     <= sym_d;
      nsym_q    <= nsym_d;
      nfft_m1_q <= nfft_m1_d;
      std_q     <= std_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

  assign up.ack = acc;
  assign dn.cyc = cyc_q;
  assign dn.stb = stb_q;
  assign dn.we  = stb_q;
  assign dn.dat = dat_q;
  assign STD_O  = std_q;
  assign BUSY_O = busy_q;
  assign DONE_O = done_q;
  assign ERR_O  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifft_sym_sched.sv
`default_nettype none
// ============================================================================
// tb_ifft_sym_sched : randomized frames against a sample-index stream model
// Revision: 1.0
// ============================================================================
module tb_ifft_sym_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] std_i;
  logic [7:0] nsym_i;
  logic [1:0] std_o;
  logic       busy_o, done_o, err_o;

  ifft_sym_sched_if up_if ();
  ifft_sym_sched_if dn_if ();

  ifft_sym_sched #(.CFG_GAP(2), .NSYM_W(8)) dut (
    .CLK_I   (clk),
    .RST_I   (rst),
    .START_I (start),
    .STD_I   (std_i),
    .NSYM_I  (nsym_i),
    .up      (up_if),
    .dn      (dn_if),
    .STD_O   (std_o),
    .BUSY_O  (busy_o),
    .DONE_O  (done_o),
    .ERR_O   (err_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n    = 0;
  int          beat_cnt = 0, frame_base = 0, done_cnt = 0, err_cnt = 0;
  int          cyc_rise_n = 0, done_n = 0, src_idx = 0;
  logic [15:0] m_tag = '0;
  logic [1:0]  m_std = '0;
  bit          up_ack_seen = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  function automatic int nfft_of(input logic [1:0] s);
    case (s)
      2'b00:   return 64;
      2'b01:   return 256;
      default: return 2048;
    endcase
  endfunction

  // Per-cycle compare: the k-th delivered beat of a frame must carry sample k of that frame.
  initial begin
    bit          prev_stall = 1'b0, done_prev = 1'b0, cyc_prev = 1'b0;
    logic [31:0] prev_dat   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall  = 1'b0;
        done_prev   = 1'b0;
        cyc_prev    = 1'b0;
        up_ack_seen = 1'b0;
      end else begin
        chk("we_eq_stb", dn_if.we, dn_if.stb);
        if (dn_if.stb) chk("stb_without_cyc", dn_if.cyc, 1);
        if (prev_stall) begin
          chk("stall_stb_dropped", dn_if.stb, 1);
          chk("stall_dat_changed", dn_if.dat, prev_dat);
        end
        if (up_if.ack) begin
          chk("ack_while_stalled", dn_if.stb & ~dn_if.ack, 0);
          chk("ack_without_offer", up_if.cyc & up_if.stb & up_if.we, 1);
          chk("ack_while_idle", busy_o, 1);
        end
        if (!busy_o) chk("idle_bus_quiet", {dn_if.cyc, dn_if.stb}, 0);
        else         chk("std_o_latched", std_o, m_std);
        if (dn_if.stb && dn_if.ack) begin
          chk("beat_dat", dn_if.dat, {m_tag, 16'(beat_cnt - frame_base)});
          beat_cnt++;
        end
        if (done_o) begin
          done_cnt++;
          done_n = cyc_n;
          chk("done_cyc_low", dn_if.cyc, 0);
          chk("done_single", done_prev, 0);
        end
        if (err_o) err_cnt++;
        if (dn_if.cyc && !cyc_prev) cyc_rise_n = cyc_n;
        prev_stall  = dn_if.stb & ~dn_if.ack;
        prev_dat    = dn_if.dat;
        done_prev   = done_o;
        cyc_prev    = dn_if.cyc;
        up_ack_seen = up_if.ack;
      end
    end
  end

  task automatic drive_up(input int ackp, input int stbp, input int drop_at);
    up_if.cyc = !(drop_at >= 0 && src_idx >= drop_at);
    up_if.stb = up_if.cyc && (int'($urandom_range(99)) < stbp);
    up_if.we  = up_if.stb && (stbp >= 100 || $urandom_range(7) != 0);
    up_if.dat = {m_tag, src_idx[15:0]};
    dn_if.ack = (int'($urandom_range(99)) < ackp);
  endtask

  task automatic frame(input logic [1:0] std, input logic [7:0] nsym, input int ackp,
                       input int stbp, input int drop_at, input int rst_at, input bit disturb,
                       input logic [15:0] tag, output int beats, output int dones,
                       output int errs, output int lat_cyc, output int lat_done);
    int exp_len, d0, e0, n0, k;
    bit fin;
    exp_len = int'(nsym) * nfft_of(std);
    @(posedge clk); #1;
    m_tag = tag; m_std = std; frame_base = beat_cnt;
    d0 = done_cnt; e0 = err_cnt; src_idx = 0; n0 = cyc_n;
    start = 1'b1; std_i = std; nsym_i = nsym;
    drive_up(ackp, stbp, drop_at);
    fin = 1'b0; k = 0;
    while (!fin && k < 4 * exp_len + 100) begin
      @(posedge clk); #1; k++;
      if (k == 1) begin start = 1'b0; std_i = 2'($urandom); nsym_i = 8'($urandom); end
      if (disturb && k == 40) begin start = 1'b1; std_i = std ^ 2'b01; nsym_i = nsym + 8'd3; end
      if (disturb && k == 41) start = 1'b0;
      if (up_ack_seen) src_idx++;
      if (rst_at >= 0 && src_idx >= rst_at) begin
        rst = 1'b1; #1;
        chk("rst_async_dat", dn_if.dat, 0);
        chk("rst_async_ctl", {dn_if.cyc, dn_if.stb, dn_if.we, std_o, busy_o, done_o, err_o, up_if.ack}, 0);
        fin = 1'b1;
      end else begin
        drive_up(ackp, stbp, drop_at);
        if (done_cnt != d0 || err_cnt != e0) fin = 1'b1;
      end
    end
    chk("frame_finished", fin, 1);
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0;
    if (rst) begin @(posedge clk); #1; rst = 1'b0; end
    k = 0;
    while (busy_o && k < 64) begin
      @(posedge clk); #1; k++;
      dn_if.ack = ($urandom_range(1) == 1);
    end
    dn_if.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_low_after_frame", busy_o, 0);
    beats    = beat_cnt - frame_base;
    dones    = done_cnt - d0;
    errs     = err_cnt - e0;
    lat_cyc  = cyc_rise_n - n0;
    lat_done = done_n - n0;
  endtask

  task automatic cfg_err(input logic [1:0] std, input logic [7:0] nsym);
    int e0;
    @(posedge clk); #1;
    e0 = err_cnt; start = 1'b1; std_i = std; nsym_i = nsym;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err_pulse", err_o, 1);
    chk("cfg_err_quiet", {busy_o, dn_if.cyc}, 0);
    @(posedge clk); #1;
    chk("cfg_err_single", err_o, 0);
    chk("cfg_err_quiet2", {busy_o, dn_if.cyc}, 0);
    @(posedge clk); #1;
    chk("cfg_err_count", err_cnt - e0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d, e, lc, ld;
    logic [1:0] rs;
    logic [7:0] rn;
    rst = 1'b1; start = 1'b0; std_i = '0; nsym_i = '0;
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0; up_if.dat = '0; dn_if.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dat", dn_if.dat, 0);
    chk("reset_ctl", {dn_if.cyc, dn_if.stb, dn_if.we, std_o, busy_o, done_o, err_o, up_if.ack}, 0);
    rst = 1'b0;

    // Full rate: samples 0..127, CYC edge after CFG_GAP+1, DONE after 1+2+128+1 cycles.
    frame(2'b00, 8'd2, 100, 100, -1, -1, 1'b0, 16'h0000, b, d, e, lc, ld);
    chk("t1_beats", b, 128);
    chk("t1_done", d, 1);
    chk("t1_err", e, 0);
    chk("t1_cyc_rise", lc, 3);
    chk("t1_latency", ld, 132);

    frame(2'b01, 8'd1, 50, 90, -1, -1, 1'b0, 16'h1A2B, b, d, e, lc, ld);
    chk("t2_beats", b, 256);
    chk("t2_done", d, 1);
    chk("t2_err", e, 0);

    cfg_err(2'b11, 8'd5);
    cfg_err(2'b00, 8'd0);

    frame(2'b00, 8'd3, 50, 90, 100, -1, 1'b0, 16'h4C4C, b, d, e, lc, ld);
    chk("t4_beats", b, 100);
    chk("t4_done", d, 0);
    chk("t4_err", e, 1);

    frame(2'b10, 8'd1, 70, 90, -1, 1000, 1'b0, 16'h5EED, b, d, e, lc, ld);
    chk("t5_abort_done", d, 0);
    chk("t5_abort_err", e, 0);
    frame(2'b10, 8'd1, 100, 100, -1, -1, 1'b0, 16'h5EEE, b, d, e, lc, ld);
    chk("t5_beats", b, 2048);
    chk("t5_done", d, 1);

    frame(2'b00, 8'd2, 60, 80, -1, -1, 1'b1, 16'h6060, b, d, e, lc, ld);
    chk("t6_beats", b, 128);
    chk("t6_done", d, 1);
    chk("t6_err", e, 0);

    for (int i = 0; i < 4; i++) begin
      rs = 2'($urandom_range(1));
      rn = 8'($urandom_range(3, 1));
      frame(rs, rn, int'($urandom_range(100, 30)), int'($urandom_range(100, 50)), -1, -1,
            1'b0, 16'($urandom), b, d, e, lc, ld);
      chk("rand_beats", b, int'(rn) * nfft_of(rs));
      chk("rand_done", d, 1);
      chk("rand_err", e, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
